// File: rtl/tmfir_sched.sv
// Time-multiplexed FIR sequencer: one tap per cycle through an external shared multiplier,
// guard-bit accumulation and saturating output with a ready/valid handshake on each side.
module tmfir_sched #(
  parameter int unsigned NTAPS = 8,
  parameter int unsigned WI1   = 4,
  parameter int unsigned WF1   = 4,
  parameter int unsigned WI2   = 4,
  parameter int unsigned WF2   = 4,
  parameter int unsigned WI0   = 8,
  parameter int unsigned WF0   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WI1+WF1-1:0]         in_data,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic [WI2+WF2-1:0]         coef_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WI0+WF0-1:0]         out_data,
  output logic                       out_ovf,
  output logic [WI1+WF1-1:0]         mul_in1,
  output logic [WI2+WF2-1:0]         mul_in2,
  input  logic [WI0+WF0-1:0]         mul_out,
  input  logic                       mul_ovf
);

  localparam int unsigned W1 = WI1 + WF1;
  localparam int unsigned W2 = WI2 + WF2;
  localparam int unsigned WO = WI0 + WF0;
  localparam int unsigned IW = $clog2(NTAPS);
  localparam int unsigned AW = WO + IW;

  localparam logic [IW-1:0] LastIdx = IW'(NTAPS - 1);
  localparam logic [WO-1:0] MaxPos  = {1'b0, {(WO-1){1'b1}}};
  localparam logic [WO-1:0] MaxNeg  = {1'b1, {(WO-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e          state_q, state_d;
  logic [W1-1:0]   x_q [NTAPS];
  logic [W1-1:0]   x_d [NTAPS];
  logic [W2-1:0]   c_q [NTAPS];
  logic [W2-1:0]   c_d [NTAPS];
  logic [IW-1:0]   idx_q, idx_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic            ovf_q, ovf_d;

  logic [AW-1:0]   prod_ext;
  logic [IW:0]     acc_hi;
  logic            in_range;

  // IW guard bits make the sum of NTAPS full-scale products exact.
  assign prod_ext = {{IW{mul_out[WO-1]}}, mul_out};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    c_d     = c_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        // Applied on the same edge as a handshake, so a simultaneous write is seen by this sample.
        if (coef_we) c_d[coef_addr] = coef_data;
        if (in_valid) begin
          for (int k = int'(NTAPS) - 1; k > 0; k--) x_d[k] = x_q[k-1];
          x_d[0]  = in_data;
          acc_d   = '0;
          ovf_d   = 1'b0;
          idx_d   = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        acc_d = acc_q + prod_ext;
        ovf_d = ovf_q | mul_ovf;
        idx_d = idx_q + 1'b1;
        if (idx_q == LastIdx) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < int'(NTAPS); k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      x_q     <= x_d;
      c_q     <= c_d;
    end
  end

  // In range when every bit above the output sign bit matches it.
  assign acc_hi   = acc_q[AW-1:WO-1];
  assign in_range = (&acc_hi) | ~(|acc_hi);

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    out_data  = '0;
    out_ovf   = 1'b0;
    mul_in1   = '0;
    mul_in2   = '0;
    if (state_q == StDone) begin
      if (in_range)        out_data = acc_q[WO-1:0];
      else if (acc_q[AW-1]) out_data = MaxNeg;
      else                 out_data = MaxPos;
      out_ovf = ovf_q | ~in_range;
    end
    if (state_q == StMac) begin
      mul_in1 = x_q[idx_q];
      mul_in2 = c_q[idx_q];
    end
  end

endmodule

// File: tb/tb_tmfir_sched.sv
// Directed bench for tmfir_sched with an exact Q4.4 x Q4.4 -> Q8.8 multiplier model.
module tb_tmfir_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [7:0]  coef_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;
  logic [7:0]  mul_in1;
  logic [7:0]  mul_in2;
  logic [15:0] mul_out;
  logic        mul_ovf;
  logic        force_ovf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Full 16-bit signed product of two Q4.4 values is exactly Q8.8 and never overflows.
  assign mul_out = $signed(mul_in1) * $signed(mul_in2);
  assign mul_ovf = force_ovf;

  tmfir_sched dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_data (coef_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .mul_in1   (mul_in1),
    .mul_in2   (mul_in2),
    .mul_out   (mul_out),
    .mul_ovf   (mul_ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic write_coef(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    @(negedge clk);
    coef_we   = 1'b0;
  endtask

  task automatic load_impulse_coefs();
    for (int k = 0; k < 8; k++) write_coef(3'(k), 8'((k + 1) * 16));
  endtask

  // Returns #1 after the handshake edge.
  task automatic push(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check_eq("push_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Handshake cycle is cycle 0; the cycle after the handshake edge is cycle 1.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat <= 40) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic run_impulse(input string tag);
    int          lat;
    logic [15:0] exp;
    load_impulse_coefs();
    for (int n = 0; n < 8; n++) begin
      push((n == 0) ? 8'h10 : 8'h00);
      wait_out(lat);
      // c[7] = 8'h80 is -8.0 in Q4.4, so the last response is -8.0 = 16'hF800.
      exp = (n < 7) ? 16'((n + 1) * 256) : 16'hF800;
      check_eq($sformatf("%s_lat%0d", tag, n), 32'(lat), 32'd9);
      check_eq($sformatf("%s_data%0d", tag, n), 32'(out_data), 32'(exp));
      check_eq($sformatf("%s_ovf%0d", tag, n), 32'(out_ovf), 32'd0);
    end
  endtask

  initial begin
    int          lat;
    int          acc;
    logic        seen;
    logic [15:0] held;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b1;
    force_ovf = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_out_ovf", 32'(out_ovf), 32'd0);
    check_eq("rst_mul_in1", 32'(mul_in1), 32'd0);
    check_eq("rst_mul_in2", 32'(mul_in2), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Impulse response
    run_impulse("imp");

    // Saturation, positive then negative
    do_reset();
    for (int k = 0; k < 8; k++) write_coef(3'(k), 8'h7F);
    for (int n = 0; n < 8; n++) begin
      push(8'h7F);
      wait_out(lat);
      acc = (n + 1) * 32'h3F01;
      check_eq($sformatf("satp_data%0d", n), 32'(out_data), (acc > 32'h7FFF) ? 32'h7FFF : acc);
      check_eq($sformatf("satp_ovf%0d", n), 32'(out_ovf), (acc > 32'h7FFF) ? 32'd1 : 32'd0);
    end
    for (int n = 0; n < 8; n++) begin
      push(8'h80);
      wait_out(lat);
    end
    check_eq("satn_data", 32'(out_data), 32'h8000);
    check_eq("satn_ovf", 32'(out_ovf), 32'd1);

    // Backpressure
    do_reset();
    write_coef(3'd0, 8'h30);
    out_ready = 1'b0;
    push(8'h10);
    wait_out(lat);
    check_eq("bp_data0", 32'(out_data), 32'h0300);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("bp_valid%0d", i), 32'(out_valid), 32'd1);
      check_eq($sformatf("bp_data%0d", i), 32'(out_data), 32'(held));
      check_eq($sformatf("bp_ovf%0d", i), 32'(out_ovf), 32'd0);
      check_eq($sformatf("bp_rdy%0d", i), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq("bp_release_rdy", 32'(in_ready), 32'd1);
    check_eq("bp_release_valid", 32'(out_valid), 32'd0);

    // Coefficient write attempted while busy
    do_reset();
    write_coef(3'd0, 8'h10);
    push(8'h10);
    @(negedge clk);
    coef_we   = 1'b1;
    coef_addr = 3'd0;
    coef_data = 8'h20;
    repeat (3) @(negedge clk);
    coef_we   = 1'b0;
    wait_out(lat);
    check_eq("cbusy_data", 32'(out_data), 32'h0100);
    push(8'h10);
    wait_out(lat);
    check_eq("cbusy_readback", 32'(out_data), 32'h0100);

    // Reset in the middle of MAC
    do_reset();
    load_impulse_coefs();
    push(8'h10);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check_eq("rmac_valid", 32'(out_valid), 32'd0);
    check_eq("rmac_rdy", 32'(in_ready), 32'd1);
    check_eq("rmac_mul_in1", 32'(mul_in1), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 seen |= out_valid;
    end
    check_eq("rmac_no_output", 32'(seen), 32'd0);
    run_impulse("rimp");

    // Multiplier overflow with an in-range sum
    do_reset();
    write_coef(3'd0, 8'h10);
    push(8'h20);
    check_eq("movf_mul_in1", 32'(mul_in1), 32'h20);
    check_eq("movf_mul_in2", 32'(mul_in2), 32'h10);
    force_ovf = 1'b1;
    @(posedge clk);
    #1 force_ovf = 1'b0;
    wait_out(lat);
    check_eq("movf_data", 32'(out_data), 32'h0200);
    check_eq("movf_ovf", 32'(out_ovf), 32'd1);
    push(8'h00);
    wait_out(lat);
    check_eq("movf_clear_data", 32'(out_data), 32'h0000);
    check_eq("movf_clear_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk);
    #1;
    check_eq("idle_mul_in1", 32'(mul_in1), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
